// File: rtl/rate_divider_sel_pkg.sv
// Shared defaults, rate index names and 50 MHz reload values for rate_divider_sel.
package rate_divider_sel_pkg;

    localparam int DEF_WIDTH     = 20;
    localparam int DEF_NUM_RATES = 4;
    localparam int DEF_CNT_W     = 4;

    localparam int RATE_FULL    = 0;
    localparam int RATE_ONE     = 1;
    localparam int RATE_HALF    = 2;
    localparam int RATE_QUARTER = 3;

    // At 50 MHz: FULL ticks every cycle; ONE/HALF/QUARTER give 50/100/200 Hz.
    localparam logic [DEF_WIDTH-1:0] RELOAD_FULL    = 20'd0;
    localparam logic [DEF_WIDTH-1:0] RELOAD_ONE     = 20'd999_999;
    localparam logic [DEF_WIDTH-1:0] RELOAD_HALF    = 20'd499_999;
    localparam logic [DEF_WIDTH-1:0] RELOAD_QUARTER = 20'd249_999;

    localparam logic [DEF_NUM_RATES*DEF_WIDTH-1:0] DEF_RATE_TABLE =
        {RELOAD_QUARTER, RELOAD_HALF, RELOAD_ONE, RELOAD_FULL};

endpackage

// File: rtl/rate_divider_sel_rate_mux.sv
// rate_mux: NUM_RATES-to-1 reload selector, combinational; out-of-range selects fall back to entry 0.
// Also reports the index actually used so the caller can record it.
module rate_mux #(
    parameter int WIDTH     = 20,
    parameter int NUM_RATES = 4,
    parameter int SEL_W     = $clog2(NUM_RATES)
) (
    input  logic [SEL_W-1:0]           sel_i,
    input  logic [NUM_RATES*WIDTH-1:0] table_i,
    output logic [WIDTH-1:0]           val_o,
    output logic [SEL_W-1:0]           idx_o
);

    always_comb begin
        val_o = table_i[WIDTH-1:0];
        idx_o = '0;
        for (int i = 1; i < NUM_RATES; i++) begin
            if (sel_i == SEL_W'(i)) begin
                val_o = table_i[i*WIDTH +: WIDTH];
                idx_o = sel_i;
            end
        end
    end

endmodule

// File: rtl/rate_divider_sel.sv
// Selectable-rate tick generator: registered outputs, tick one edge after count hits 0.
// No backpressure; enable_i low freezes the period, restart_i reloads immediately.
module rate_divider_sel
    import rate_divider_sel_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_RATES = DEF_NUM_RATES,
    parameter int SEL_W     = $clog2(NUM_RATES),
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       enable_i,
    input  logic                       restart_i,
    input  logic [SEL_W-1:0]           rate_sel_i,
    input  logic [NUM_RATES*WIDTH-1:0] rate_table_i,
    output logic                       tick_o,
    output logic [WIDTH-1:0]           count_o,
    output logic [SEL_W-1:0]           active_sel_o,
    output logic [CNT_W-1:0]           tick_count_o
);

    logic [WIDTH-1:0] reload;
    logic [SEL_W-1:0] reload_sel;

    logic [WIDTH-1:0] count_q, count_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    rate_mux #(
        .WIDTH     (WIDTH),
        .NUM_RATES (NUM_RATES),
        .SEL_W     (SEL_W)
    ) u_rate_mux (
        .sel_i   (rate_sel_i),
        .table_i (rate_table_i),
        .val_o   (reload),
        .idx_o   (reload_sel)
    );

    // rate_sel_i is only looked at on a reload, so mid-period changes wait for the boundary.
    always_comb begin
        count_d = count_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        tcnt_d  = tcnt_q;
        if (restart_i) begin
            count_d = reload;
            sel_d   = reload_sel;
        end else if (enable_i) begin
            if (count_q == '0) begin
                tick_d  = 1'b1;
                count_d = reload;
                sel_d   = reload_sel;
                tcnt_d  = tcnt_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= rate_table_i[WIDTH-1:0];
            sel_q   <= '0;
            tick_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            count_q <= count_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign tick_o       = tick_q;
    assign count_o      = count_q;
    assign active_sel_o = sel_q;
    assign tick_count_o = tcnt_q;

endmodule

// File: tb/tb_rate_divider_sel.sv
// Directed-vector bench for rate_divider_sel: a 4-rate instance and a 3-rate instance for out-of-range selects.
module tb_rate_divider_sel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, table {0,3,7,15}
    logic        rst_a = 1'b1, en_a = 1'b0, rs_a = 1'b0;
    logic [1:0]  sel_a = 2'd0;
    logic [31:0] tbl_a = {8'd15, 8'd7, 8'd3, 8'd0};
    logic        tick_a;
    logic [7:0]  cnt_a;
    logic [1:0]  act_a;
    logic [3:0]  tc_a;

    rate_divider_sel #(.WIDTH(8), .NUM_RATES(4), .SEL_W(2), .CNT_W(4)) dut_a (
        .clock_i      (clk),
        .reset_i      (rst_a),
        .enable_i     (en_a),
        .restart_i    (rs_a),
        .rate_sel_i   (sel_a),
        .rate_table_i (tbl_a),
        .tick_o       (tick_a),
        .count_o      (cnt_a),
        .active_sel_o (act_a),
        .tick_count_o (tc_a)
    );

    // Instance B: NUM_RATES=3, table {2,5,9}
    logic        rst_b = 1'b1, en_b = 1'b0, rs_b = 1'b0;
    logic [1:0]  sel_b = 2'd0;
    logic [23:0] tbl_b = {8'd9, 8'd5, 8'd2};
    logic        tick_b;
    logic [7:0]  cnt_b;
    logic [1:0]  act_b;
    logic [3:0]  tc_b;

    rate_divider_sel #(.WIDTH(8), .NUM_RATES(3), .SEL_W(2), .CNT_W(4)) dut_b (
        .clock_i      (clk),
        .reset_i      (rst_b),
        .enable_i     (en_b),
        .restart_i    (rs_b),
        .rate_sel_i   (sel_b),
        .rate_table_i (tbl_b),
        .tick_o       (tick_b),
        .count_o      (cnt_b),
        .active_sel_o (act_b),
        .tick_count_o (tc_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst, en, rs;
        logic [1:0] sel;
        logic       tick;
        logic [7:0] cnt;
        logic [1:0] act;
        logic [3:0] tc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic en, input logic rs, input logic [1:0] sel,
                       input logic tick, input logic [7:0] cnt, input logic [1:0] act,
                       input logic [3:0] tc);
        vec_t v;
        v.rst = rst; v.en = en; v.rs = rs; v.sel = sel;
        v.tick = tick; v.cnt = cnt; v.act = act; v.tc = tc;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step_a(input logic rst, input logic en, input logic rs, input logic [1:0] sel);
        rst_a = rst; en_a = en; rs_a = rs; sel_a = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic rst, input logic en, input logic rs, input logic [1:0] sel);
        rst_b = rst; en_b = en; rs_b = rs; sel_b = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            step_a(vq[i].rst, vq[i].en, vq[i].rs, vq[i].sel);
            chk($sformatf("vec%0d_tick", i), {31'd0, tick_a}, {31'd0, vq[i].tick});
            chk($sformatf("vec%0d_count", i), {24'd0, cnt_a}, {24'd0, vq[i].cnt});
            chk($sformatf("vec%0d_active", i), {30'd0, act_a}, {30'd0, vq[i].act});
            chk($sformatf("vec%0d_tcnt", i), {28'd0, tc_a}, {28'd0, vq[i].tc});
        end
    endtask

    int part2;

    initial begin
        // Reset, then entry 0 (R=0) ticks at once and loads R(1)=3
        add(1,1,0,1, 0,0,0,0);
        add(0,1,0,1, 1,3,1,1);
        add(0,1,0,1, 0,2,1,1);
        add(0,1,0,1, 0,1,1,1);
        add(0,1,0,1, 0,0,1,1);
        add(0,1,0,1, 1,3,1,2);
        add(0,1,0,1, 0,2,1,2);
        add(0,1,0,1, 0,1,1,2);
        add(0,1,0,1, 0,0,1,2);
        add(0,1,0,1, 1,3,1,3);
        part2 = vq.size();
        // Divide-by-1 via restart to sel 0, then a hold cycle
        add(0,1,1,0, 0,0,0,1);
        add(0,1,0,0, 1,0,0,2);
        add(0,1,0,0, 1,0,0,3);
        add(0,1,0,0, 1,0,0,4);
        add(0,0,0,0, 0,0,0,4);
        // Restart on a terminal-count cycle: no tick, count 7, tick_count held
        add(0,1,1,2, 0,7,2,4);
        add(0,1,0,2, 0,6,2,4);
        add(0,1,0,2, 0,5,2,4);
        for (int i = 0; i < 5; i++) add(0,0,0,2, 0,5,2,4);
        for (int c = 4; c >= 0; c--) add(0,1,0,2, 0,8'(c),2,4);
        add(0,1,0,2, 1,7,2,5);
        add(0,1,1,3, 0,15,3,5);

        run_vecs(0, part2);

        // 14 more periods of 4 cycles; tick_count wraps 15 -> 0 on the 13th
        for (int k = 1; k <= 14; k++) begin
            for (int j = 0; j < 3; j++) begin
                step_a(0,1,0,1);
                chk($sformatf("wrap%0d_idle", k), {31'd0, tick_a}, 32'd0);
            end
            step_a(0,1,0,1);
            chk($sformatf("wrap%0d_tick", k), {31'd0, tick_a}, 32'd1);
            chk($sformatf("wrap%0d_tcnt", k), {28'd0, tc_a}, (3 + k) % 16);
        end

        run_vecs(part2, vq.size());

        // Deferred rate change: sel 3 running, switch to 1 once count reaches 10
        for (int c = 14; c >= 10; c--) begin
            step_a(0,1,0,3);
            chk("defer_pre_count", {24'd0, cnt_a}, c);
        end
        for (int c = 9; c >= 0; c--) begin
            step_a(0,1,0,1);
            chk("defer_count", {24'd0, cnt_a}, c);
            chk("defer_active_held", {30'd0, act_a}, 32'd3);
            chk("defer_no_tick", {31'd0, tick_a}, 32'd0);
        end
        step_a(0,1,0,1);
        chk("defer_tick", {31'd0, tick_a}, 32'd1);
        chk("defer_active_new", {30'd0, act_a}, 32'd1);
        chk("defer_reload", {24'd0, cnt_a}, 32'd3);
        chk("defer_tcnt", {28'd0, tc_a}, 32'd6);
        for (int c = 2; c >= 0; c--) begin
            step_a(0,1,0,1);
            chk("defer_next_idle", {31'd0, tick_a}, 32'd0);
        end
        step_a(0,1,0,1);
        chk("defer_next_tick", {31'd0, tick_a}, 32'd1);
        chk("defer_next_tcnt", {28'd0, tc_a}, 32'd7);

        // Reset mid-period discards the partial period
        step_a(0,1,0,1);
        chk("midrst_pre_count", {24'd0, cnt_a}, 32'd2);
        step_a(1,1,0,1);
        chk("midrst_count", {24'd0, cnt_a}, 32'd0);
        chk("midrst_active", {30'd0, act_a}, 32'd0);
        chk("midrst_tcnt", {28'd0, tc_a}, 32'd0);
        chk("midrst_tick", {31'd0, tick_a}, 32'd0);
        step_a(1,0,0,0);

        // Out-of-range select on the 3-rate instance
        step_b(1,1,0,3);
        chk("oor_reset_count", {24'd0, cnt_b}, 32'd2);
        chk("oor_reset_active", {30'd0, act_b}, 32'd0);
        step_b(0,1,1,1);
        chk("oor_restart_count", {24'd0, cnt_b}, 32'd5);
        chk("oor_restart_active", {30'd0, act_b}, 32'd1);
        for (int c = 4; c >= 0; c--) begin
            step_b(0,1,0,3);
            chk("oor_count", {24'd0, cnt_b}, c);
        end
        for (int p = 1; p <= 2; p++) begin
            step_b(0,1,0,3);
            chk($sformatf("oor_tick%0d", p), {31'd0, tick_b}, 32'd1);
            chk($sformatf("oor_active%0d", p), {30'd0, act_b}, 32'd0);
            chk($sformatf("oor_reload%0d", p), {24'd0, cnt_b}, 32'd2);
            chk($sformatf("oor_tcnt%0d", p), {28'd0, tc_b}, p);
            step_b(0,1,0,3);
            chk($sformatf("oor_idle%0d_a", p), {31'd0, tick_b}, 32'd0);
            step_b(0,1,0,3);
            chk($sformatf("oor_idle%0d_b", p), {31'd0, tick_b}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
